btn_fifo_ctrl: RTL

- Front-panel controller that turns two raw push-buttons (write, read) and a switch bank into single-cycle FIFO write/read strobes.
- One shared sample-tick counter clocks the debounce logic of both buttons.
- Adds edge detection, hold-to-auto-repeat, full/empty gating and round-robin arbitration when both requests are pending.
- Sits between the board I/O and the FIFO in the ZedBoard FIFO demo.

---
 rtl/btn_fifo_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/btn_fifo_ctrl.sv
// btn_fifo_ctrl: front-panel controller turning two raw push-buttons and a
// switch bank into single-cycle FIFO write/read strobes.
//
// Ports:
//   clk, rst_n       - system clock, asynchronous active-low reset
//   btn_wr, btn_rd   - raw buttons (asynchronous to clk)
//   sw[WIDTH]        - raw switch data (asynchronous to clk)
//   full, empty      - FIFO status flags, sampled in the grant cycle
//   wr_en, wr_data   - single-cycle write strobe and its data
//   rd_en            - single-cycle read strobe
//   err_ovf, err_udf - one-cycle pulse when a write/read is dropped
//   db_wr, db_rd     - debounced button levels
//
// Per-button signals are held in 2-entry arrays: index 0 = write, 1 = read.
module btn_fifo_ctrl #(
  parameter int WIDTH      = 8,
  parameter int TICK_W     = 16,
  parameter int STABLE     = 4,
  parameter int HOLD_TICKS = 64,
  parameter int RPT_TICKS  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_wr,
  input  logic             btn_rd,
  input  logic [WIDTH-1:0] sw,
  input  logic             full,
  input  logic             empty,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             rd_en,
  output logic             err_ovf,
  output logic             err_udf,
  output logic             db_wr,
  output logic             db_rd
);

  localparam int CW = $clog2(HOLD_TICKS + RPT_TICKS + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] WRAP_C = CW'(HOLD_TICKS + RPT_TICKS);

  typedef enum logic {GNT_WR, GNT_RD} gnt_t;

  logic [1:0]        btn_s1, btn_s2;
  logic [WIDTH-1:0]  sw_s1, sw_s2;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  logic [STABLE-1:0] hist   [2];
  logic [STABLE-1:0] hist_n [2];
  logic [CW-1:0]     hcnt   [2];
  logic [CW-1:0]     hcnt_n [2];
  logic [1:0]        db, db_n, rep, req_n, req_q, pend;

  gnt_t              last;
  logic [WIDTH-1:0]  data_q;
  logic              eff_wr, eff_rd, tie, gnt_wr, gnt_rd;

  assign tick  = &tick_cnt;
  assign db_wr = db[0];
  assign db_rd = db[1];

  // Debounce, hold counter and request generation. Edge and repeat requests
  // are both produced on tick edges so repeat spacing is exact in clk cycles.
  // A repeat only fires while the debounced level stays high across the tick.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      hist_n[i] = tick ? {hist[i][STABLE-2:0], btn_s2[i]} : hist[i];
      db_n[i]   = db[i];
      if (tick && (&hist_n[i]))
        db_n[i] = 1'b1;
      else if (tick && !(|hist_n[i]))
        db_n[i] = 1'b0;

      hcnt_n[i] = hcnt[i];
      rep[i]    = 1'b0;
      if (!db_n[i]) begin
        hcnt_n[i] = '0;
      end else if (tick && db[i]) begin
        if (hcnt[i] + 1'b1 == WRAP_C) begin
          hcnt_n[i] = HOLD_C;
          rep[i]    = 1'b1;
        end else begin
          hcnt_n[i] = hcnt[i] + 1'b1;
          rep[i]    = (hcnt[i] + 1'b1 == HOLD_C);
        end
      end
      req_n[i] = (db_n[i] & ~db[i]) | rep[i];
    end
  end

  // Arbiter: a fresh request counts as pending in its own cycle so an
  // uncontested strobe follows the request by one cycle. last-grant only
  // moves on a tie.
  always_comb begin
    eff_wr = pend[0] | req_q[0];
    eff_rd = pend[1] | req_q[1];
    tie    = eff_wr & eff_rd;
    gnt_wr = eff_wr & (~eff_rd | (last == GNT_RD));
    gnt_rd = eff_rd & ~gnt_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      tick_cnt <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        hist[i] <= '0;
        hcnt[i] <= '0;
      end
      db       <= '0;
      req_q    <= '0;
      pend     <= '0;
      last     <= GNT_RD;
      data_q   <= '0;
      wr_en    <= 1'b0;
      wr_data  <= '0;
      rd_en    <= 1'b0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
    end else begin
      btn_s1   <= {btn_rd, btn_wr};
      btn_s2   <= btn_s1;
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      tick_cnt <= tick_cnt + 1'b1;
      for (int unsigned i = 0; i < 2; i++) begin
        hist[i] <= hist_n[i];
        hcnt[i] <= hcnt_n[i];
      end
      db    <= db_n;
      req_q <= req_n;

      // A request arriving while already pending is dropped, data included.
      if (req_q[0] && !pend[0])
        data_q <= sw_s2;

      pend[0] <= eff_wr & ~gnt_wr;
      pend[1] <= eff_rd & ~gnt_rd;

      wr_en   <= gnt_wr & ~full;
      err_ovf <= gnt_wr & full;
      rd_en   <= gnt_rd & ~empty;
      err_udf <= gnt_rd & empty;

      // Same-cycle request and grant bypasses data_q.
      if (gnt_wr && !full)
        wr_data <= (req_q[0] && !pend[0]) ? sw_s2 : data_q;

      if (tie)
        last <= gnt_wr ? GNT_WR : GNT_RD;
    end
  end

endmodule
